// File: rtl/bch_normal_t12_encoder_if.sv
// ---------------------------------------------------------------------------
// bch_normal_t12_encoder_if
//
// Byte-stream bundle for the t=12 normal-frame BCH encoder. It carries the
// information-byte input stream (s_*), the encoded output stream (m_*) and
// the frame-length error pulse.
//
//   s_valid  upstream byte valid
//   s_sof    first information byte of a frame (qualified by s_valid)
//   s_data   information byte, MSB first in time
//   s_ready  encoder accepts s_data this cycle
//   m_valid  output byte valid
//   m_data   output byte: information bytes, then 24 parity bytes
//   m_sof    first byte of the output frame
//   m_eof    last parity byte of the output frame
//   m_ready  downstream accepts m_data this cycle
//   len_err  one-cycle pulse when a frame is restarted mid-frame
//
// Modports:
//   slave  - the encoder side
//   master - the side that feeds the encoder and drains its output
// ---------------------------------------------------------------------------
interface bch_normal_t12_encoder_if;
  logic       s_valid;
  logic       s_sof;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eof;
  logic       m_ready;
  logic       len_err;

  modport slave (
    input  s_valid, s_sof, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eof, len_err
  );

  modport master (
    output s_valid, s_sof, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eof, len_err
  );
endinterface

// File: rtl/bch_normal_t12_encoder.sv
// ---------------------------------------------------------------------------
// bch_normal_t12_encoder
//
// Systematic BCH encoder for the normal frame, t=12 code (192 parity bits).
// Information bytes are passed through to the output with one cycle of
// latency while a 192-bit remainder is updated eight bit-steps per byte.
// After KBCH_BYTES information bytes the remainder is emitted as 24 parity
// bytes, most significant byte first, the last one flagged with m_eof.
//
// Parameters:
//   KBCH_BYTES  information length in bytes (4026 for the normal frame)
//   GEN_POLY    generator coefficients g191..g0; the x^192 term is implicit
//
// Ports:
//   clk_1x  block clock, all state changes on its rising edge
//   rst     asynchronous active-high reset
//   bus     bch_normal_t12_encoder_if.slave (s_* in, m_* out, len_err)
//
// Build option:
//   BCH_LEN_ERR_EN  when defined, a start-of-frame byte arriving in the
//                   middle of a frame pulses len_err, discards the partial
//                   frame and restarts encoding with that byte as byte 0.
//                   When undefined, s_sof is ignored mid-frame and len_err
//                   is held low.
// ---------------------------------------------------------------------------
module bch_normal_t12_encoder #(
  parameter int           KBCH_BYTES = 4026,
  parameter logic [191:0] GEN_POLY   = 192'h0
) (
  input  logic                      clk_1x,
  input  logic                      rst,
  bch_normal_t12_encoder_if.slave   bus
);

  localparam int          DATA_W    = 8;
  localparam int          PAR_W     = 192;
  localparam logic [12:0] LAST_IDX  = 13'(KBCH_BYTES - 1);
  localparam logic [4:0]  PAR_LAST  = 5'd23;
  localparam logic [4:0]  PAR_DONE  = 5'd24;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  logic [1:0]        state;
  logic [PAR_W-1:0]  rem;
  logic [12:0]       byte_cnt;
  logic [4:0]        par_idx;

  logic [DATA_W-1:0] m_data_r;
  logic              m_valid_r;
  logic              m_sof_r;
  logic              m_eof_r;

  logic              out_free;
  logic              in_xfer;
  logic              frame_start;
  logic              frame_restart;
  logic              frame_cont;

  // Eight LFSR steps, MSB of the byte first. Each step divides by g(x):
  // the bit leaving rem[191] xored with the incoming data bit decides
  // whether the generator is folded back in.
  function automatic logic [PAR_W-1:0] rem_step(input logic [PAR_W-1:0] r_in,
                                                input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] r;
    logic             fb;
    r = r_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = d[i] ^ r[PAR_W-1];
      r  = {r[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : {PAR_W{1'b0}});
    end
    return r;
  endfunction

  // The output register can take a new byte when it is empty or its
  // current byte is leaving this cycle.
  assign out_free    = ~m_valid_r | bus.m_ready;

  // Reset gating keeps s_ready low for the whole reset interval, not only
  // after the first clock edge.
  assign bus.s_ready = ~rst & (state != ST_PARITY) & out_free;
  assign in_xfer     = bus.s_valid & bus.s_ready;

`ifdef BCH_LEN_ERR_EN
  assign frame_restart = in_xfer & bus.s_sof & (state == ST_DATA);
`else
  assign frame_restart = 1'b0;
`endif

  assign frame_start = (in_xfer & bus.s_sof & (state == ST_IDLE)) | frame_restart;
  assign frame_cont  = in_xfer & (state == ST_DATA) & ~frame_restart;

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      byte_cnt  <= '0;
      par_idx   <= '0;
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
      m_sof_r   <= 1'b0;
      m_eof_r   <= 1'b0;
    end else if (frame_start) begin
      // Byte 0: remainder starts from zero regardless of any partial frame.
      rem       <= rem_step('0, bus.s_data);
      byte_cnt  <= 13'd1;
      par_idx   <= '0;
      m_data_r  <= bus.s_data;
      m_valid_r <= 1'b1;
      m_sof_r   <= 1'b1;
      m_eof_r   <= 1'b0;
      // A one-byte frame goes straight to parity.
      state     <= (LAST_IDX == 13'd0) ? ST_PARITY : ST_DATA;
    end else if (frame_cont) begin
      rem       <= rem_step(rem, bus.s_data);
      byte_cnt  <= byte_cnt + 13'd1;
      par_idx   <= '0;
      m_data_r  <= bus.s_data;
      m_valid_r <= 1'b1;
      m_sof_r   <= 1'b0;
      m_eof_r   <= 1'b0;
      if (byte_cnt == LAST_IDX) begin
        state <= ST_PARITY;
      end
    end else if ((state == ST_PARITY) && out_free) begin
      if (par_idx == PAR_DONE) begin
        // The eof byte is leaving now; the register empties and the next
        // frame may be accepted on the following cycle.
        state     <= ST_IDLE;
        byte_cnt  <= '0;
        m_valid_r <= 1'b0;
        m_eof_r   <= 1'b0;
      end else begin
        // Shifting the remainder out leaves it all-zero after the frame.
        m_data_r  <= rem[PAR_W-1 -: DATA_W];
        rem       <= {rem[PAR_W-DATA_W-1:0], {DATA_W{1'b0}}};
        m_valid_r <= 1'b1;
        m_sof_r   <= 1'b0;
        m_eof_r   <= (par_idx == PAR_LAST);
        par_idx   <= par_idx + 5'd1;
      end
    end else if (out_free) begin
      // Nothing new to present (includes non-sof bytes dropped in IDLE).
      m_valid_r <= 1'b0;
    end
  end

`ifdef BCH_LEN_ERR_EN
  logic len_err_r;

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) begin
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= frame_restart;
    end
  end

  assign bus.len_err = len_err_r;
`else
  assign bus.len_err = 1'b0;
`endif

  assign bus.m_data  = m_data_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_sof   = m_sof_r;
  assign bus.m_eof   = m_eof_r;

endmodule

// File: tb/tb_bch_normal_t12_encoder.sv
// ---------------------------------------------------------------------------
// tb_bch_normal_t12_encoder
//
// Bench for the t=12 normal-frame BCH encoder. A full-length instance
// (KBCH_BYTES=4026) and a one-byte instance (KBCH_BYTES=1) share clk_1x/rst.
// Expected output bytes {sof, eof, data} are queued when input bytes are
// accepted; parity comes from a polynomial long-division model.
// ---------------------------------------------------------------------------
module tb_bch_normal_t12_encoder;

  localparam int           KB   = 4026;
  localparam logic [191:0] TB_G =
    192'hc3a5_9e17_42bd_08f6_7a1c_e953_2d4b_b860_15f7_3e29_a6d0_4c8b;

`ifdef BCH_LEN_ERR_EN
  localparam bit TB_LEN_EN = 1'b1;
`else
  localparam bit TB_LEN_EN = 1'b0;
`endif

  logic clk_1x = 1'b0;
  logic rst    = 1'b0;

  always #5 clk_1x = ~clk_1x;

  bch_normal_t12_encoder_if ifa ();
  bch_normal_t12_encoder_if ifb ();

  bch_normal_t12_encoder #(.KBCH_BYTES(KB), .GEN_POLY(TB_G)) dut (
    .clk_1x (clk_1x),
    .rst    (rst),
    .bus    (ifa.slave)
  );

  bch_normal_t12_encoder #(.KBCH_BYTES(1), .GEN_POLY(TB_G)) dut1 (
    .clk_1x (clk_1x),
    .rst    (rst),
    .bus    (ifb.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];
  logic [7:0] frame [0:4095];
  int         step_no       = 0;
  int         last_eof_step = -1;
  int         first_acc_step = -1;
  int         out_idx       = 0;
  int         eof_at_idx    = -1;
  int         lerr_seen     = 0;
  bit         hold_pend     = 1'b0;
  logic [9:0] hold_val      = '0;
  bit         stall_mode    = 1'b0;
  bit         lerr_exp      = 1'b0;
  bit         frame_active  = 1'b0;

  // m(x)*x^192 mod g(x) by long division over frame[base .. base+n-1].
  function automatic logic [191:0] ref_parity(input int base, input int n);
    logic [192:0] r;
    logic         b;
    r = '0;
    for (int k = 0; k < n * 8 + 192; k++) begin
      b = (k < n * 8) ? frame[base + k / 8][7 - (k % 8)] : 1'b0;
      r = {r[191:0], b};
      if (r[192]) r = r ^ {1'b1, TB_G};
    end
    return r[191:0];
  endfunction

  // One clock of the full-length instance: check outputs at the falling
  // edge, report whether the input byte is taken at the next rising edge.
  task automatic clk_step(output bit acc);
    logic [9:0] got;
    logic [9:0] exp;
    @(negedge clk_1x);
    step_no++;
    got = {ifa.m_sof, ifa.m_eof, ifa.m_data};
    if (hold_pend) begin
      n_checks++;
      if (ifa.m_valid !== 1'b1 || got !== hold_val) begin
        n_fail++;
        $display("FAIL stall_hold step %0d: got v=%b %h, required v=1 %h",
                 step_no, ifa.m_valid, got, hold_val);
      end
    end
    n_checks++;
    if (ifa.len_err !== lerr_exp) begin
      n_fail++;
      $display("FAIL len_err step %0d: got %b, required %b", step_no, ifa.len_err, lerr_exp);
    end
    if (ifa.len_err === 1'b1) lerr_seen++;
    if (ifa.m_valid === 1'b1 && ifa.m_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_extra step %0d: got %h, required no output", step_no, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL out_byte %0d: got {sof,eof,data}=%h, required %h", out_idx, got, exp);
        end
      end
      if (got[8] === 1'b1) begin
        last_eof_step = step_no;
        eof_at_idx    = out_idx;
      end
      out_idx++;
    end
    hold_pend = (ifa.m_valid === 1'b1) && (ifa.m_ready === 1'b0);
    hold_val  = got;
    acc       = (ifa.s_valid === 1'b1) && (ifa.s_ready === 1'b1);
    lerr_exp  = TB_LEN_EN && acc && ifa.s_sof && frame_active;
    @(posedge clk_1x);
    #1;
    ifa.m_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Feed a frame of n information bytes from frame[]; a byte at restart_at
  // carries s_sof. Stops early (no parity queued) after byte stop_at.
  task automatic drive_frame(input int n, input int restart_at, input bit gaps,
                             input int stop_at);
    int          i;
    int          base;
    int          budget;
    bit          acc;
    bit          sof;
    bit          sof_out;
    logic [191:0] p;
    i = 0; base = 0; budget = 0;
    while ((i - base) < n) begin
      sof = (i == 0) || (i == restart_at);
      ifa.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ifa.s_sof   = sof;
      ifa.s_data  = frame[i];
      clk_step(acc);
      if (acc) begin
        if (i == 0) first_acc_step = step_no;
        sof_out = (i == 0) || (TB_LEN_EN && i == restart_at);
        if (TB_LEN_EN && i == restart_at) base = i;
        exp_q.push_back({sof_out, 1'b0, frame[i]});
        frame_active = 1'b1;
        if (i == stop_at) return;
        i++;
      end
      budget++;
      if (budget > 40000) begin
        n_checks++; n_fail++;
        $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i - base, n);
        frame_active = 1'b0;
        return;
      end
    end
    frame_active = 1'b0;
    p = ref_parity(base, n);
    for (int j = 0; j < 24; j++) exp_q.push_back({1'b0, (j == 23), p[191 - 8 * j -: 8]});
  endtask

  task automatic wait_drain();
    bit acc;
    int budget;
    ifa.s_valid = 1'b0;
    ifa.s_sof   = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 || ifa.m_valid === 1'b1) begin
      clk_step(acc);
      budget++;
      if (budget > 30000) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
        exp_q.delete();
        return;
      end
    end
    for (int k = 0; k < 4; k++) clk_step(acc);
  endtask

  task automatic test_reset();
    ifa.s_valid = 1'b0; ifa.s_sof = 1'b0; ifa.s_data = '0; ifa.m_ready = 1'b1;
    ifb.s_valid = 1'b0; ifb.s_sof = 1'b0; ifb.s_data = '0; ifb.m_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_1x);
    @(negedge clk_1x);
    n_checks++;
    if ({ifa.s_ready, ifa.m_valid, ifa.m_sof, ifa.m_eof, ifa.len_err, ifa.m_data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b v=%b sof=%b eof=%b le=%b d=%h, required all 0",
               ifa.s_ready, ifa.m_valid, ifa.m_sof, ifa.m_eof, ifa.len_err, ifa.m_data);
    end
    n_checks++;
    if ({ifb.s_ready, ifb.m_valid, ifb.m_sof, ifb.m_eof, ifb.len_err, ifb.m_data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_k1: got rdy=%b v=%b d=%h, required all 0",
               ifb.s_ready, ifb.m_valid, ifb.m_data);
    end
    @(posedge clk_1x); #1 rst = 1'b0;
    @(negedge clk_1x);
    n_checks++;
    if (ifa.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", ifa.s_ready);
    end
    @(posedge clk_1x); #1;
  endtask

  task automatic test_kbch1();
    logic [9:0]   eq[$];
    logic [191:0] g;
    logic [9:0]   got;
    logic [9:0]   exp;
    g = TB_G;
    // x^192 mod g(x) is exactly the low 192 generator coefficients.
    eq.push_back({1'b1, 1'b0, 8'h01});
    for (int k = 0; k < 24; k++) eq.push_back({1'b0, (k == 23), g[191 - 8 * k -: 8]});
    ifb.s_valid = 1'b1; ifb.s_sof = 1'b1; ifb.s_data = 8'h01;
    @(negedge clk_1x);
    n_checks++;
    if (ifb.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL k1_accept: s_ready got %b, required 1", ifb.s_ready);
    end
    @(posedge clk_1x); #1;
    ifb.s_valid = 1'b0; ifb.s_sof = 1'b0;
    for (int c = 0; c < 80 && eq.size() != 0; c++) begin
      @(negedge clk_1x);
      n_checks++;
      if (ifb.s_ready !== 1'b0 || ifb.len_err !== 1'b0) begin
        n_fail++;
        $display("FAIL k1_parity_ready: s_ready=%b len_err=%b, required 0 0", ifb.s_ready, ifb.len_err);
      end
      if (ifb.m_valid === 1'b1 && ifb.m_ready === 1'b1) begin
        got = {ifb.m_sof, ifb.m_eof, ifb.m_data};
        exp = eq.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL k1_byte %0d: got %h, required %h", 24 - eq.size(), got, exp);
        end
      end
    end
    n_checks++;
    if (eq.size() != 0) begin
      n_fail++;
      $display("FAIL k1_count: %0d bytes missing, required 0", eq.size());
    end
    repeat (2) @(posedge clk_1x);
    #1;
  endtask

  task automatic test_zero_frame();
    for (int k = 0; k < 4096; k++) frame[k] = 8'h00;
    out_idx = 0; eof_at_idx = -1;
    drive_frame(KB, -1, 1'b0, -1);
    wait_drain();
    n_checks++;
    if (eof_at_idx != 4049) begin
      n_fail++;
      $display("FAIL zero_eof_index: got %0d, required 4049", eof_at_idx);
    end
  endtask

  task automatic test_random_stall();
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    stall_mode = 1'b1;
    drive_frame(KB, -1, 1'b1, -1);
    wait_drain();
    stall_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    drive_frame(KB, -1, 1'b0, -1);
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    drive_frame(KB, -1, 1'b0, -1);
    n_checks++;
    if (first_acc_step != last_eof_step + 1) begin
      n_fail++;
      $display("FAIL b2b_sof_timing: accepted at step %0d, required %0d",
               first_acc_step, last_eof_step + 1);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit acc;
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    drive_frame(KB, -1, 1'b0, 100);
    rst = 1'b1;
    @(negedge clk_1x);
    n_checks++;
    if ({ifa.s_ready, ifa.m_valid, ifa.m_sof, ifa.m_eof, ifa.len_err, ifa.m_data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b v=%b d=%h, required all 0",
               ifa.s_ready, ifa.m_valid, ifa.m_data);
    end
    exp_q.delete();
    hold_pend = 1'b0; lerr_exp = 1'b0; frame_active = 1'b0;
    @(posedge clk_1x); #1 rst = 1'b0;
    // Bytes without sof after reset must be swallowed silently.
    ifa.s_valid = 1'b1; ifa.s_sof = 1'b0; ifa.s_data = 8'h5a;
    repeat (3) begin
      clk_step(acc);
      n_checks++;
      if (!acc) begin
        n_fail++;
        $display("FAIL reset_mid_drop_accept: got %b, required 1", acc);
      end
    end
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    drive_frame(KB, -1, 1'b0, -1);
    wait_drain();
  endtask

  task automatic test_len_err();
    for (int k = 0; k < 4096; k++) frame[k] = 8'($urandom);
    lerr_seen = 0;
    drive_frame(KB, 50, 1'b0, -1);
    wait_drain();
    n_checks++;
    if (lerr_seen != (TB_LEN_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL len_err_pulses: got %0d, required %0d", lerr_seen, TB_LEN_EN ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_kbch1();
    test_zero_frame();
    test_random_stall();
    test_back_to_back();
    test_reset_mid();
    test_len_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
